// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, operand build, RAW scoreboard and a
// single registered issue slot under a valid/ready handshake.
module decode_issue_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 2,
    parameter int CTRL_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [DATA_W-1:0] pc_seq_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              wr_en,
    input  logic [1:0]        dest_sel,
    input  logic              a_sel,
    input  logic              b_sel,
    input  logic              imm_zext,
    input  logic              imm_up,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a_out,
    output logic [DATA_W-1:0] op_b_out,
    output logic [DATA_W-1:0] rt_data_out,
    output logic [RA_W-1:0]   dest_out,
    output logic              wr_en_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] pc_seq_out,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_err
);

    localparam int NREG = 1 << RA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Maps a 5-bit MIPS register field onto RA_W bits (truncate or zero-pad).
    function automatic logic [RA_W-1:0] fld(input logic [4:0] f);
        logic [RA_W-1:0] r;
        r = '0;
        for (int i = 0; i < 5 && i < RA_W; i++) r[i] = f[i];
        return r;
    endfunction

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];

    logic [RA_W-1:0]   rs_addr, rt_addr, rd_addr, dest_raw, dest_eff;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] rs_data, rt_data, imm_val, op_a, op_b;
    logic              rs_pend, rt_pend, dest_full, hazard, issue;
    logic              sb_inc, sb_dec, same_reg, err_set;
    logic              unused_opcode;

    assign unused_opcode = ^instr_in[31:26];

    assign rs_addr = fld(instr_in[25:21]);
    assign rt_addr = fld(instr_in[20:16]);
    assign rd_addr = fld(instr_in[15:11]);
    assign imm16   = instr_in[15:0];

    always_comb begin
        dest_raw = '0;
        case (dest_sel)
            2'd0:    dest_raw = rt_addr;
            2'd1:    dest_raw = rd_addr;
            2'd2:    dest_raw = fld(5'd31);
            default: dest_raw = '0;
        endcase
    end

    assign dest_eff = wr_en ? dest_raw : '0;

    // A writeback in flight this cycle is forwarded straight to the readers.
    assign rs_data = (rs_addr == '0) ? '0 :
                     (wb_en && wb_dest == rs_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 :
                     (wb_en && wb_dest == rt_addr) ? wb_data : regs[rt_addr];

    always_comb begin
        imm_val = '0;
        if (imm_up)
            imm_val = DATA_W'({imm16, 16'h0000});
        else if (imm_zext)
            imm_val = DATA_W'(imm16);
        else
            imm_val = DATA_W'($signed(imm16));
    end

    assign op_a = a_sel ? DATA_W'(instr_in[10:6]) : rs_data;
    assign op_b = b_sel ? imm_val : rt_data;

    // The last outstanding write retiring this cycle no longer blocks a reader.
    assign rs_pend = (rs_addr != '0) && (cnt[rs_addr] != '0) &&
                     !(wb_en && wb_dest == rs_addr && cnt[rs_addr] == CNT_W'(1));
    assign rt_pend = (rt_addr != '0) && (cnt[rt_addr] != '0) &&
                     !(wb_en && wb_dest == rt_addr && cnt[rt_addr] == CNT_W'(1));
    assign dest_full = (dest_eff != '0) && (cnt[dest_eff] == CNT_MAX);

    assign hazard   = (uses_rs && rs_pend) || (uses_rt && rt_pend) || dest_full;
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    assign sb_inc   = issue && (dest_eff != '0);
    assign sb_dec   = wb_en && (wb_dest != '0);
    assign same_reg = sb_inc && sb_dec && (dest_eff == wb_dest);
    assign err_set  = !flush && sb_dec && !same_reg && (cnt[wb_dest] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_dest != '0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            sb_err <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (!same_reg && sb_inc && dest_eff == RA_W'(i))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!same_reg && sb_dec && wb_dest == RA_W'(i) && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (err_set) sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            op_a_out    <= '0;
            op_b_out    <= '0;
            rt_data_out <= '0;
            dest_out    <= '0;
            wr_en_out   <= 1'b0;
            ctrl_out    <= '0;
            pc_seq_out  <= '0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            op_a_out    <= op_a;
            op_b_out    <= op_b;
            rt_data_out <= rt_data;
            dest_out    <= dest_eff;
            wr_en_out   <= wr_en;
            ctrl_out    <= ctrl_in;
            pc_seq_out  <= pc_seq_in;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed plus randomized bench for decode_issue_stage, checked against a
// register/scoreboard reference model kept in plain arrays.
module tb_decode_issue_stage;

    localparam int DATA_W  = 32;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 2;
    localparam int CTRL_W  = 14;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush, in_valid, in_ready;
    logic [31:0]       instr_in;
    logic [DATA_W-1:0] pc_seq_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              uses_rs, uses_rt, wr_en;
    logic [1:0]        dest_sel;
    logic              a_sel, b_sel, imm_zext, imm_up;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] op_a_out, op_b_out, rt_data_out;
    logic [RA_W-1:0]   dest_out;
    logic              wr_en_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] pc_seq_out;
    logic              wb_en;
    logic [RA_W-1:0]   wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              sb_err;

    int vectors = 0;
    int miscompares = 0;

    int unsigned mregs [32];
    int          mcnt  [32];
    bit          m_valid, m_err;
    int unsigned m_a, m_b, m_rt, m_dest, m_wr, m_ctrl, m_pc;

    always #5 clk = ~clk;

    decode_issue_stage #(
        .DATA_W(DATA_W), .RA_W(RA_W), .CNT_W(CNT_W), .CTRL_W(CTRL_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_seq_in(pc_seq_in), .ctrl_in(ctrl_in),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .wr_en(wr_en),
        .dest_sel(dest_sel), .a_sel(a_sel), .b_sel(b_sel),
        .imm_zext(imm_zext), .imm_up(imm_up),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a_out(op_a_out), .op_b_out(op_b_out), .rt_data_out(rt_data_out),
        .dest_out(dest_out), .wr_en_out(wr_en_out), .ctrl_out(ctrl_out),
        .pc_seq_out(pc_seq_out),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .sb_err(sb_err)
    );

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 0;
        foreach (mcnt[i]) mcnt[i] = 0;
        m_valid = 0; m_err = 0;
        m_a = 0; m_b = 0; m_rt = 0; m_dest = 0; m_wr = 0; m_ctrl = 0; m_pc = 0;
    endtask

    function automatic int unsigned read_reg(input int unsigned r);
        if (r == 0) return 0;
        if (wb_en && wb_dest == r) return wb_data;
        return mregs[r];
    endfunction

    function automatic bit is_pending(input int unsigned r);
        return r != 0 && mcnt[r] > 0 && !(wb_en && wb_dest == r && mcnt[r] == 1);
    endfunction

    function automatic logic [31:0] mk(input int unsigned rs, input int unsigned rt,
                                       input int unsigned low);
        logic [31:0] w;
        w = 32'h0000_0021;
        w[25:21] = rs[4:0];
        w[20:16] = rt[4:0];
        w[15:0]  = low[15:0];
        return w;
    endfunction

    task automatic apply_stimulus();
        flush = 0; in_valid = 0; instr_in = 0; pc_seq_in = 0; ctrl_in = 0;
        uses_rs = 0; uses_rt = 0; wr_en = 0; dest_sel = 0;
        a_sel = 0; b_sel = 0; imm_zext = 0; imm_up = 0; out_ready = 1;
        wb_en = 0; wb_dest = 0; wb_data = 0;
    endtask

    // Inputs are already driven; model one clock and compare before/after it.
    task automatic step_cycle();
        int unsigned rs, rt, rd, sh, imm, dest, bimm, a, b, rtd;
        bit hz, rdy, iss, inc, dec;
        #1;
        rs = instr_in[25:21]; rt = instr_in[20:16]; rd = instr_in[15:11];
        sh = instr_in[10:6];  imm = instr_in[15:0];
        case (dest_sel)
            2'd0: dest = rt;
            2'd1: dest = rd;
            2'd2: dest = 31;
            default: dest = 0;
        endcase
        hz = (uses_rs && is_pending(rs)) || (uses_rt && is_pending(rt)) ||
             (wr_en && dest != 0 && mcnt[dest] == CNT_MAX);
        rdy = !flush && !hz && (!m_valid || out_ready);
        check_output("in_ready", in_ready, rdy);
        iss = in_valid && rdy;
        if (imm_up) bimm = imm << 16;
        else if (imm_zext) bimm = imm;
        else bimm = (imm >= 32768) ? (imm | 32'hFFFF_0000) : imm;
        a = a_sel ? sh : read_reg(rs);
        rtd = read_reg(rt);
        b = b_sel ? bimm : rtd;
        if (iss) begin
            m_valid = 1; m_a = a; m_b = b; m_rt = rtd;
            m_dest = wr_en ? dest : 0; m_wr = wr_en; m_ctrl = ctrl_in; m_pc = pc_seq_in;
        end else if (flush || out_ready) begin
            m_valid = 0;
        end
        inc = iss && wr_en && dest != 0;
        dec = wb_en && wb_dest != 0;
        if (flush) begin
            foreach (mcnt[i]) mcnt[i] = 0;
        end else if (!(inc && dec && dest == wb_dest)) begin
            if (inc) mcnt[dest]++;
            if (dec) begin
                if (mcnt[wb_dest] == 0) m_err = 1;
                else mcnt[wb_dest]--;
            end
        end
        if (wb_en && wb_dest != 0) mregs[wb_dest] = wb_data;
        @(posedge clk);
        #1;
        check_output("out_valid", out_valid, m_valid);
        check_output("op_a_out", op_a_out, m_a);
        check_output("op_b_out", op_b_out, m_b);
        check_output("rt_data_out", rt_data_out, m_rt);
        check_output("dest_out", 32'(dest_out), m_dest);
        check_output("wr_en_out", 32'(wr_en_out), m_wr);
        check_output("ctrl_out", 32'(ctrl_out), m_ctrl);
        check_output("pc_seq_out", pc_seq_out, m_pc);
        check_output("sb_err", 32'(sb_err), 32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        int unsigned start, r;
        reset = 0;
        apply_stimulus();
        model_reset();
        #2;
        check_output("rst_out_valid", 32'(out_valid), 0);
        check_output("rst_op_a", op_a_out, 0);
        check_output("rst_op_b", op_b_out, 0);
        check_output("rst_dest", 32'(dest_out), 0);
        check_output("rst_sb_err", 32'(sb_err), 0);
        check_output("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1;

        // $5 = 0x1234 via a real pending write, then addu reads it.
        in_valid = 1; instr_in = mk(0, 5, 0); wr_en = 1; dest_sel = 0;
        step_cycle();
        apply_stimulus(); wb_en = 1; wb_dest = 5; wb_data = 32'h1234;
        step_cycle();
        apply_stimulus(); in_valid = 1; instr_in = mk(5, 0, 10 << 11);
        uses_rs = 1; uses_rt = 1; pc_seq_in = 32'h0040_0004; ctrl_in = 14'h1A5;
        step_cycle();
        check_output("addu_op_a", op_a_out, 32'h1234);
        check_output("addu_valid", 32'(out_valid), 1);

        // RAW on $8 resolved by a same-cycle writeback.
        apply_stimulus(); in_valid = 1; instr_in = mk(0, 0, 8 << 11); wr_en = 1; dest_sel = 1;
        step_cycle();
        apply_stimulus(); in_valid = 1; instr_in = mk(8, 0, 0); uses_rs = 1;
        step_cycle();
        step_cycle();
        check_output("raw_stall", 32'(in_ready), 0);
        wb_en = 1; wb_dest = 8; wb_data = 32'hBEEF;
        step_cycle();
        check_output("bypass_op_a", op_a_out, 32'hBEEF);

        // Immediate extension variants of 0x8000.
        apply_stimulus(); in_valid = 1; instr_in = mk(0, 0, 16'h8000); b_sel = 1;
        step_cycle();
        check_output("imm_sext", op_b_out, 32'hFFFF_8000);
        imm_zext = 1;
        step_cycle();
        check_output("imm_zext", op_b_out, 32'h0000_8000);
        imm_up = 1;
        step_cycle();
        check_output("imm_up", op_b_out, 32'h8000_0000);

        // Backpressure: slot frozen for three cycles, then one issue per cycle.
        apply_stimulus(); in_valid = 1; out_ready = 0; instr_in = mk(5, 8, 16'h0140);
        a_sel = 1; pc_seq_in = 32'h100; ctrl_in = 14'h3;
        for (int i = 0; i < 3; i++) step_cycle();
        check_output("bp_valid", 32'(out_valid), 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            pc_seq_in = 32'h200 + 4 * i;
            step_cycle();
            check_output("bp_pc", pc_seq_out, 32'h200 + 4 * i);
        end

        // Scoreboard saturation on $3, then flush clears it.
        apply_stimulus(); in_valid = 1; instr_in = mk(0, 3, 0); wr_en = 1;
        for (int i = 0; i < 4; i++) step_cycle();
        check_output("sat_stall", 32'(in_ready), 0);
        flush = 1;
        step_cycle();
        check_output("flush_valid", 32'(out_valid), 0);
        apply_stimulus(); in_valid = 1; instr_in = mk(3, 0, 0); uses_rs = 1;
        step_cycle();
        check_output("post_flush_issue", 32'(out_valid), 1);

        // Random traffic; writebacks only retire genuinely pending registers.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            instr_in  = $urandom;
            instr_in[25:21] = 5'($urandom_range(0, 7));
            instr_in[20:16] = 5'($urandom_range(0, 7));
            instr_in[15:11] = 5'($urandom_range(0, 7));
            uses_rs  = 1'($urandom_range(0, 1));
            uses_rt  = 1'($urandom_range(0, 1));
            wr_en    = 1'($urandom_range(0, 1));
            dest_sel = 2'($urandom_range(0, 3));
            a_sel    = 1'($urandom_range(0, 1));
            b_sel    = 1'($urandom_range(0, 1));
            imm_zext = 1'($urandom_range(0, 1));
            imm_up   = 1'($urandom_range(0, 1));
            pc_seq_in = $urandom;
            ctrl_in   = 14'($urandom);
            wb_data   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    r = (start + k) % 32;
                    if (!wb_en && mcnt[r] > 0) begin
                        wb_en = 1; wb_dest = 5'(r);
                    end
                end
            end else if ($urandom_range(0, 9) == 0) begin
                wb_en = 1; wb_dest = 0;
            end
            step_cycle();
        end

        // Writeback to $0 is ignored; to an idle $9 flags sb_err for good.
        apply_stimulus(); flush = 1;
        step_cycle();
        apply_stimulus(); wb_en = 1; wb_dest = 0; wb_data = 32'hFFFF;
        step_cycle();
        check_output("wb0_no_err", 32'(sb_err), 0);
        apply_stimulus(); in_valid = 1; instr_in = mk(0, 0, 0); uses_rs = 1;
        step_cycle();
        check_output("reg0_reads_zero", op_a_out, 0);
        apply_stimulus(); wb_en = 1; wb_dest = 9; wb_data = 32'h9;
        step_cycle();
        check_output("sb_err_set", 32'(sb_err), 1);
        apply_stimulus();
        step_cycle();
        step_cycle();
        check_output("sb_err_sticky", 32'(sb_err), 1);

        // Asynchronous reset in mid-operation.
        apply_stimulus(); in_valid = 1; instr_in = mk(0, 4, 0); wr_en = 1; out_ready = 0;
        step_cycle();
        reset = 0;
        #1;
        check_output("async_valid", 32'(out_valid), 0);
        check_output("async_sb_err", 32'(sb_err), 0);
        check_output("async_dest", 32'(dest_out), 0);
        model_reset();
        @(negedge clk);
        reset = 1;
        apply_stimulus(); in_valid = 1; instr_in = mk(4, 0, 0); uses_rs = 1;
        step_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
